// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;

   localparam logic [DEF_DATA_W-1:0] NOP_OPCODE = 8'h00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HELD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instr_fetch_unit_if.sv
// Controller <-> fetch unit bus: fetch/jump/halt control, boot-load port and fetch results.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);

   logic              fetch_req;
   logic              jump;
   logic [ADDR_W-1:0] branch_target;
   logic              halt;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [DATA_W-1:0] prog_data;
   logic [DATA_W-1:0] instruction;
   logic              instr_valid;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              prog_err;

   modport master (
      output fetch_req, jump, branch_target, halt, prog_we, prog_addr, prog_data,
      input  instruction, instr_valid, pc, busy, prog_err
   );

   modport slave (
      input  fetch_req, jump, branch_target, halt, prog_we, prog_addr, prog_data,
      output instruction, instr_valid, pc, busy, prog_err
   );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_prog_mem.sv
// Program memory: one synchronous write port, one synchronous read port, contents not reset.
module prog_mem #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage array write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end else begin
         mem_q[waddr_i] <= mem_q[waddr_i];
      end
   end

   // Registered read port
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end else begin
         rdata_q <= rdata_q;
      end
   end

   assign rdata_o = rdata_q;

endmodule : prog_mem

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program counter, fetch FSM and instruction output register
// in front of an on-chip program memory with a boot-load write port.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = 256
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   instr_fetch_unit_if.slave  bus_io
);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] instr_q;
   logic              valid_q;
   logic              busy_q;
   logic              err_q;

   logic              fetch_accept_s;
   logic [ADDR_W-1:0] fetch_addr_s;
   logic              wr_accept_s;
   logic              wr_reject_s;
   logic [DATA_W-1:0] mem_rdata_s;

   // Fetch acceptance and program-write arbitration for the current cycle
   always_comb begin
      fetch_accept_s = 1'b0;
      fetch_addr_s   = pc_q;
      wr_accept_s    = 1'b0;
      wr_reject_s    = 1'b0;

      if (bus_io.jump) begin
         fetch_addr_s = bus_io.branch_target;
      end else begin
         fetch_addr_s = pc_q;
      end

      if (!bus_io.halt && bus_io.fetch_req && (state_q == IDLE || state_q == HELD)) begin
         fetch_accept_s = 1'b1;
      end else begin
         fetch_accept_s = 1'b0;
      end

      // Writes are only safe while no read can be in flight or starting.
      if (bus_io.prog_we) begin
         if ((state_q == IDLE || state_q == HALTED) && !fetch_accept_s) begin
            wr_accept_s = 1'b1;
         end else begin
            wr_reject_s = 1'b1;
         end
      end else begin
         wr_accept_s = 1'b0;
         wr_reject_s = 1'b0;
      end
   end

   // The read is launched at the accepting edge so its data is ready at the FETCH edge.
   prog_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_prog_mem (
      .clk_i   (clk_i),
      .we_i    (wr_accept_s),
      .waddr_i (bus_io.prog_addr),
      .wdata_i (bus_io.prog_data),
      .re_i    (fetch_accept_s),
      .raddr_i (fetch_addr_s),
      .rdata_o (mem_rdata_s)
   );

   // Fetch FSM with PC and registered outputs
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         pc_q    <= {ADDR_W{1'b0}};
         addr_q  <= {ADDR_W{1'b0}};
         instr_q <= NOP_OPCODE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q <= wr_reject_s;
         if (bus_io.halt) begin
            state_q <= HALTED;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE, HELD: begin
                  if (bus_io.fetch_req) begin
                     addr_q  <= fetch_addr_s;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b1;
                     state_q <= FETCH;
                  end else if (bus_io.jump) begin
                     pc_q <= bus_io.branch_target;
                  end else begin
                     state_q <= state_q;
                  end
               end
               FETCH: begin
                  instr_q <= mem_rdata_s;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b0;
                  pc_q    <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                  state_q <= HELD;
               end
               HALTED: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus_io.instruction = instr_q;
   assign bus_io.instr_valid = valid_q;
   assign bus_io.pc          = pc_q;
   assign bus_io.busy        = busy_q;
   assign bus_io.prog_err    = err_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
      .clk_i    (clk),
      .reset_ni (reset_n),
      .bus_io   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.fetch_req     = 1'b0;
      bus.jump          = 1'b0;
      bus.branch_target = 8'h00;
      bus.halt          = 1'b0;
      bus.prog_we       = 1'b0;
      bus.prog_addr     = 8'h00;
      bus.prog_data     = 8'h00;
   endtask

   task automatic prog_write(input logic [7:0] addr, input logic [7:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = addr;
      bus.prog_data = data;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   // Two-cycle fetch; checks the in-flight cycle and the delivered word.
   task automatic do_fetch(input string tag, input logic use_jump, input logic [7:0] target,
                           input logic [7:0] exp_instr, input logic [7:0] exp_pc);
      bus.fetch_req     = 1'b1;
      bus.jump          = use_jump;
      bus.branch_target = target;
      tick();
      bus.fetch_req     = 1'b0;
      bus.jump          = 1'b0;
      check({tag, "_busy"}, 8'(bus.busy), 8'h01);
      check({tag, "_vld0"}, 8'(bus.instr_valid), 8'h00);
      tick();
      check({tag, "_instr"}, bus.instruction, exp_instr);
      check({tag, "_vld1"}, 8'(bus.instr_valid), 8'h01);
      check({tag, "_idle"}, 8'(bus.busy), 8'h00);
      check({tag, "_pc"}, bus.pc, exp_pc);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();
      reset_n = 1'b0;
      repeat (3) tick();
      check("rst_pc", bus.pc, 8'h00);
      check("rst_instr", bus.instruction, 8'h00);
      check("rst_valid", 8'(bus.instr_valid), 8'h00);
      check("rst_busy", 8'(bus.busy), 8'h00);
      check("rst_err", 8'(bus.prog_err), 8'h00);
      reset_n = 1'b1;
      tick();

      // Boot load in IDLE
      prog_write(8'h00, 8'hA1);
      prog_write(8'h01, 8'hB2);
      prog_write(8'h02, 8'hC3);
      prog_write(8'h40, 8'h5D);
      prog_write(8'hFF, 8'hE7);
      check("load_err", 8'(bus.prog_err), 8'h00);
      check("load_pc", bus.pc, 8'h00);

      // Sequential fetches
      do_fetch("seq0", 1'b0, 8'h00, 8'hA1, 8'h01);
      do_fetch("seq1", 1'b0, 8'h00, 8'hB2, 8'h02);
      do_fetch("seq2", 1'b0, 8'h00, 8'hC3, 8'h03);

      // Jump combined with fetch
      do_fetch("jmpf", 1'b1, 8'h40, 8'h5D, 8'h41);

      // Jump alone in HELD keeps the delivered word, then fetch wraps the PC
      bus.jump          = 1'b1;
      bus.branch_target = 8'hFF;
      tick();
      bus.jump          = 1'b0;
      check("jmp_pc", bus.pc, 8'hFF);
      check("jmp_instr", bus.instruction, 8'h5D);
      check("jmp_valid", 8'(bus.instr_valid), 8'h01);
      check("jmp_busy", 8'(bus.busy), 8'h00);
      do_fetch("wrap", 1'b0, 8'h00, 8'hE7, 8'h00);

      // Halt during FETCH aborts the fetch
      bus.fetch_req = 1'b1;
      tick();
      bus.fetch_req = 1'b0;
      check("hlt_busy", 8'(bus.busy), 8'h01);
      bus.halt = 1'b1;
      tick();
      check("hlt_valid", 8'(bus.instr_valid), 8'h00);
      check("hlt_busy0", 8'(bus.busy), 8'h00);
      check("hlt_pc", bus.pc, 8'h00);
      check("hlt_instr", bus.instruction, 8'hE7);
      prog_write(8'h05, 8'h77);
      check("hlt_wr_err", 8'(bus.prog_err), 8'h00);
      tick();
      check("hlt_hold_pc", bus.pc, 8'h00);
      bus.halt = 1'b0;
      tick();
      do_fetch("hlt_wr", 1'b1, 8'h05, 8'h77, 8'h06);

      // Rejected write in HELD
      prog_write(8'h01, 8'hFF);
      check("rej_err1", 8'(bus.prog_err), 8'h01);
      tick();
      check("rej_err0", 8'(bus.prog_err), 8'h00);
      do_fetch("rej_chk", 1'b1, 8'h01, 8'hB2, 8'h02);

      // Rejected write during FETCH
      bus.fetch_req     = 1'b1;
      bus.jump          = 1'b1;
      bus.branch_target = 8'h02;
      tick();
      bus.fetch_req     = 1'b0;
      bus.jump          = 1'b0;
      prog_write(8'h02, 8'h00);
      check("frej_instr", bus.instruction, 8'hC3);
      check("frej_err", 8'(bus.prog_err), 8'h01);
      tick();
      check("frej_err0", 8'(bus.prog_err), 8'h00);
      do_fetch("frej_chk", 1'b1, 8'h02, 8'hC3, 8'h03);

      // Asynchronous reset between edges while a fetch is in flight
      bus.fetch_req = 1'b1;
      tick();
      bus.fetch_req = 1'b0;
      check("ar_busy", 8'(bus.busy), 8'h01);
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_pc", bus.pc, 8'h00);
      check("ar_instr", bus.instruction, 8'h00);
      check("ar_valid", 8'(bus.instr_valid), 8'h00);
      check("ar_busy0", 8'(bus.busy), 8'h00);
      tick();
      reset_n = 1'b1;
      tick();
      check("ar_after_pc", bus.pc, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_instr_fetch_unit
